seven_segment_mux_driver: RTL and testbench

Parametrised N-digit multiplexed seven-segment driver with a sequential binary-to-BCD converter, inter-digit blanking, overflow indication and per-digit decimal points. Sits between datapath blocks that produce a binary count and the board's common-anode display pins. It is the multi-digit successor to the fixed three-digit display driver, with a load/busy handshake in place of continuous combinational division.

---
 rtl/seven_segment_mux_driver.sv | 203 ++++++++++++++++++++
 tb/tb_seven_segment_mux_driver.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_mux_driver.sv
// N-digit multiplexed common-anode seven-segment driver with sequential
// double-dabble conversion. Optional macro: SEVEN_SEG_LZB_EN (leading-zero blanking).
module seven_segment_mux_driver #(
   parameter int DIGITS         = 4,
   parameter int VALUE_W        = 14,
   parameter int REFRESH_CYCLES = 100000,
   parameter int BLANK_CYCLES   = 1000
) (
   input  logic                CLOCK,
   input  logic                RESET,
   input  logic [VALUE_W-1:0]  number,
   input  logic                load,
   input  logic [DIGITS-1:0]   dp_mask,
   output logic                busy,
   output logic                overflow,
   output logic [DIGITS-1:0]   an,
   output logic [6:0]          seg,
   output logic                dp
);

   localparam int BW = 4 * DIGITS;
   localparam int CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
   localparam int SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int KW = $clog2(VALUE_W + 1);
   localparam longint unsigned MAXV = 64'(10 ** DIGITS) - 64'd1;
   localparam logic [6:0] SEG_OFF  = 7'b1111111;
   localparam logic [6:0] SEG_DASH = 7'b0111111;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [VALUE_W-1:0]  r_bin;
   logic [BW-1:0]       r_bcd;
   logic [BW-1:0]       w_bcd_adj;
   logic [KW-1:0]       r_cnt;
   logic [DIGITS-1:0]   r_dp_l;
   logic                r_ovf_l;
   logic [BW-1:0]       r_disp;
   logic [DIGITS-1:0]   r_dpm;
   logic                r_ovf;
   logic [CW-1:0]       r_ref;
   logic [SW-1:0]       r_slot;
   logic [DIGITS-1:0]   r_an;
   logic [6:0]          r_seg;
   logic                r_dp;
   logic [3:0]          w_dig;
   logic                w_dpsel;
   logic                w_blank;
   logic                w_accept;

   function automatic logic [6:0] f_seg(input logic [3:0] d);
      case (d)
         4'd0:    f_seg = 7'b1000000;
         4'd1:    f_seg = 7'b1111001;
         4'd2:    f_seg = 7'b0100100;
         4'd3:    f_seg = 7'b0110000;
         4'd4:    f_seg = 7'b0011001;
         4'd5:    f_seg = 7'b0010010;
         4'd6:    f_seg = 7'b0000010;
         4'd7:    f_seg = 7'b1111000;
         4'd8:    f_seg = 7'b0000000;
         4'd9:    f_seg = 7'b0010000;
         default: f_seg = SEG_OFF;
      endcase
   endfunction

   assign w_accept = load && (r_state == S_IDLE);
   assign busy     = (r_state != S_IDLE);
   assign overflow = r_ovf;
   assign an       = r_an;
   assign seg      = r_seg;
   assign dp       = r_dp;

   // Converter state register
   always_ff @(posedge CLOCK) begin
      if (RESET) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Converter next-state: IDLE -> SHIFT (VALUE_W cycles) -> DONE -> IDLE
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next = S_SHIFT;
         S_SHIFT: if (r_cnt == KW'(VALUE_W - 1)) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Double-dabble: add 3 to every BCD nibble that is 5 or more
   always_comb begin
      w_bcd_adj = r_bcd;
      for (int i = 0; i < DIGITS; i++) begin
         if (r_bcd[4*i +: 4] >= 4'd5)
            w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
   end

   // Conversion datapath; display registers load atomically in DONE only
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         r_bin   <= '0;
         r_bcd   <= '0;
         r_cnt   <= '0;
         r_dp_l  <= '0;
         r_ovf_l <= 1'b0;
         r_disp  <= '0;
         r_dpm   <= '0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_bin   <= number;
                  r_dp_l  <= dp_mask;
                  r_ovf_l <= (64'(number) > MAXV);
                  r_bcd   <= '0;
                  r_cnt   <= '0;
               end
            end
            S_SHIFT: begin
               r_bcd <= {w_bcd_adj[BW-2:0], r_bin[VALUE_W-1]};
               r_bin <= r_bin << 1;
               r_cnt <= r_cnt + 1'b1;
            end
            S_DONE: begin
               r_disp <= r_bcd;
               r_dpm  <= r_dp_l;
               r_ovf  <= r_ovf_l;
            end
            default: ;
         endcase
      end
   end

   // Refresh counter and slot index, scanning MSD down to LSD
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         r_ref  <= '0;
         r_slot <= SW'(DIGITS - 1);
      end else if (r_ref == CW'(REFRESH_CYCLES - 1)) begin
         r_ref  <= '0;
         r_slot <= (r_slot == '0) ? SW'(DIGITS - 1) : r_slot - 1'b1;
      end else begin
         r_ref <= r_ref + 1'b1;
      end
   end

   // Select the digit, decimal point and blanking state of the active slot
   always_comb begin
      w_dig   = '0;
      w_dpsel = 1'b0;
      w_blank = 1'b0;
`ifdef SEVEN_SEG_LZB_EN
      begin
         logic              v_lz;
         logic [DIGITS-1:0] v_lzv;
         v_lz  = 1'b1;
         v_lzv = '0;
         for (int i = DIGITS - 1; i >= 0; i--) begin
            v_lz     = v_lz && (r_disp[4*i +: 4] == 4'd0);
            v_lzv[i] = v_lz;
         end
         for (int i = 0; i < DIGITS; i++) begin
            if (r_slot == SW'(i))
               w_blank = (i != 0) && v_lzv[i] && !r_ovf;
         end
      end
`else
      w_blank = 1'b0;
`endif
      for (int i = 0; i < DIGITS; i++) begin
         if (r_slot == SW'(i)) begin
            w_dig   = r_disp[4*i +: 4];
            w_dpsel = r_dpm[i];
         end
      end
   end

   // Registered pin outputs with an all-off window at the start of each slot
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         r_an  <= '1;
         r_seg <= SEG_OFF;
         r_dp  <= 1'b1;
      end else if (r_ref < CW'(BLANK_CYCLES)) begin
         r_an  <= '1;
         r_seg <= SEG_OFF;
         r_dp  <= 1'b1;
      end else begin
         r_an  <= ~(DIGITS'(1) << r_slot);
         r_seg <= r_ovf ? SEG_DASH : (w_blank ? SEG_OFF : f_seg(w_dig));
         r_dp  <= ~w_dpsel;
      end
   end

endmodule

// File: tb/tb_seven_segment_mux_driver.sv
// Bench for seven_segment_mux_driver: directed scenarios plus random loads,
// checked every cycle against an arithmetic reference model.
module tb_seven_segment_mux_driver;

   localparam int DIGITS  = 4;
   localparam int VALUE_W = 14;
   localparam int RC      = 8;
   localparam int BC      = 2;
`ifdef SEVEN_SEG_LZB_EN
   localparam bit LZB = 1'b1;
`else
   localparam bit LZB = 1'b0;
`endif

   logic        CLOCK = 1'b0;
   logic        RESET = 1'b1;
   logic [13:0] number = '0;
   logic        load = 1'b0;
   logic [3:0]  dp_mask = '0;
   logic        busy;
   logic        overflow;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;

   always #5 CLOCK = ~CLOCK;

   seven_segment_mux_driver #(
      .DIGITS(DIGITS),
      .VALUE_W(VALUE_W),
      .REFRESH_CYCLES(RC),
      .BLANK_CYCLES(BC)
   ) dut (
      .CLOCK(CLOCK),
      .RESET(RESET),
      .number(number),
      .load(load),
      .dp_mask(dp_mask),
      .busy(busy),
      .overflow(overflow),
      .an(an),
      .seg(seg),
      .dp(dp)
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic [6:0] SEG_T [10] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
   };

   // model state: edges since reset, shown value, pending conversion
   int         m_n = 0;
   int         m_val = 0;
   logic [3:0] m_dpm = '0;
   bit         m_ovf = 1'b0;
   bit         m_acc_v = 1'b0;
   int         m_acc = 0;
   bit         m_busy = 1'b0;
   int         p_val = 0;
   logic [3:0] p_dp = '0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int pow10(input int k);
      int p = 1;
      for (int i = 0; i < k; i++) p *= 10;
      return p;
   endfunction

   task automatic step(input bit rst, input bit ld, input int num,
                       input logic [3:0] dpm);
      logic [3:0] e_an;
      logic [6:0] e_seg;
      logic       e_dp;
      int         rf;
      int         sl;
      int         dg;
      @(negedge CLOCK);
      RESET   = rst;
      load    = ld;
      number  = num[13:0];
      dp_mask = dpm;
      @(posedge CLOCK);
      #1;
      e_an  = 4'hF;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
      if (rst) begin
         m_n = 0; m_val = 0; m_dpm = '0; m_ovf = 0;
         m_acc_v = 0; m_busy = 0;
      end else begin
         rf = m_n % RC;
         sl = DIGITS - 1 - (m_n / RC) % DIGITS;
         if (rf >= BC) begin
            e_an[sl] = 1'b0;
            dg = (m_val / pow10(sl)) % 10;
            if (m_ovf) e_seg = 7'b0111111;
            else if (LZB && sl > 0 && m_val < pow10(sl)) e_seg = 7'h7F;
            else e_seg = SEG_T[dg];
            e_dp = ~m_dpm[sl];
         end
         if (ld && !m_busy) begin
            m_acc_v = 1; m_acc = m_n; p_val = num; p_dp = dpm;
         end
         if (m_acc_v && m_n == m_acc + VALUE_W + 1) begin
            m_val = p_val; m_dpm = p_dp;
            m_ovf = (p_val > pow10(DIGITS) - 1);
         end
         m_busy = m_acc_v && m_n >= m_acc && m_n <= m_acc + VALUE_W;
         m_n++;
      end
      check("an", 32'(an), 32'(e_an));
      check("seg", 32'(seg), 32'(e_seg));
      check("dp", 32'(dp), 32'(e_dp));
      check("busy", 32'(busy), 32'(m_busy));
      check("overflow", 32'(overflow), 32'(m_ovf));
   endtask

   task automatic run(input int k);
      for (int i = 0; i < k; i++) step(1'b0, 1'b0, 0, 4'h0);
   endtask

   task automatic ld(input int v, input logic [3:0] m);
      step(1'b0, 1'b1, v, m);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int bl;
      int v;
      step(1'b1, 1'b0, 0, 4'h0);
      step(1'b1, 1'b0, 0, 4'h0);
      run(32);

      ld(1234, 4'b0100);
      bl = busy ? 1 : 0;
      for (int i = 0; i < 30; i++) begin
         step(1'b0, 1'b0, 0, 4'h0);
         if (busy) bl++;
      end
      check("busy_len", 32'(bl), 32'd15);
      run(40);

      ld(9999, 4'b0000);
      run(50);
      ld(10000, 4'b1010);
      run(50);

      ld(5678, 4'b0001);
      run(2);
      ld(42, 4'b1111);
      run(50);

      ld(1234, 4'b0100);
      run(6);
      step(1'b1, 1'b0, 0, 4'h0);
      run(40);

      ld(7, 4'b0000);
      run(40);

      for (int it = 0; it < 40; it++) begin
         v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 99))
                                         : int'($urandom_range(0, 16383));
         ld(v, 4'($urandom));
         for (int g = 0; g < int'($urandom_range(0, 45)); g++) begin
            if ($urandom_range(0, 39) == 0)
               step(1'b1, 1'b0, 0, 4'h0);
            else if ($urandom_range(0, 7) == 0)
               ld(int'($urandom_range(0, 16383)), 4'($urandom));
            else
               step(1'b0, 1'b0, 0, 4'h0);
         end
      end
      run(40);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
